// File: rtl/product_rr_scheduler.sv
// Round-robin scheduler sharing one unary product unit among N_REQ requesters.
// Optional ZERO_BYPASS_EN: zero-operand jobs skip the product unit and respond with 0.
module product_rr_scheduler #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*WIDTH-1:0]     req_w,
  input  logic [N_REQ*WIDTH-1:0]     req_x,
  output logic [N_REQ-1:0]           req_ready,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(N_REQ)-1:0]   rsp_id,
  output logic [2*WIDTH-1:0]         rsp_prod,
  output logic                       pu_load,
  output logic [WIDTH-1:0]           pu_w,
  output logic [WIDTH-1:0]           pu_x,
  input  logic                       pu_out,
  input  logic                       pu_done
);
  // state | meaning
  // IDLE  | arbitrate; grant and capture one operand pair
  // LOAD  | one-cycle start strobe to the product unit
  // RUN   | count unary pulses until pu_done
  // RESP  | hold product until the consumer accepts it
  localparam int ID_W  = $clog2(N_REQ);
  localparam int ACC_W = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, RESP} state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0]  pu_w_q, pu_w_d;
  logic [WIDTH-1:0]  pu_x_q, pu_x_d;
  logic [ACC_W-1:0]  acc_q, acc_d;

  logic              grant_found;
  logic [ID_W-1:0]   grant_idx;
  logic [WIDTH-1:0]  grant_w;
  logic [WIDTH-1:0]  grant_x;
  int                cand;

  // First valid requester at or after rr_ptr, wrapping modulo N_REQ.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = (int'(rr_ptr_q) + k) % N_REQ;
      if (!grant_found && req_valid[ID_W'(cand)]) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(cand);
      end
    end
  end

  assign grant_w = req_w[grant_idx*WIDTH +: WIDTH];
  assign grant_x = req_x[grant_idx*WIDTH +: WIDTH];

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    rsp_id_d  = rsp_id_q;
    pu_w_d    = pu_w_q;
    pu_x_d    = pu_x_q;
    acc_d     = acc_q;
    req_ready = '0;
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          req_ready[grant_idx] = 1'b1;
          pu_w_d   = grant_w;
          pu_x_d   = grant_x;
          rsp_id_d = grant_idx;
          acc_d    = '0;
          rr_ptr_d = (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
`ifdef ZERO_BYPASS_EN
          if (grant_w == '0 || grant_x == '0) state_d = RESP;
          else                                state_d = LOAD;
`else
          state_d  = LOAD;
`endif
        end
      end
      LOAD: state_d = RUN;
      RUN: begin
        // Saturate rather than wrap if the unit over-counts.
        if (pu_out && acc_q != '1) acc_d = acc_q + 1'b1;
        if (pu_done) state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      rsp_id_q <= '0;
      pu_w_q   <= '0;
      pu_x_q   <= '0;
      acc_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      rsp_id_q <= rsp_id_d;
      pu_w_q   <= pu_w_d;
      pu_x_q   <= pu_x_d;
      acc_q    <= acc_d;
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign rsp_id    = rsp_id_q;
  assign rsp_prod  = acc_q;
  assign pu_load   = (state_q == LOAD);
  assign pu_w      = pu_w_q;
  assign pu_x      = pu_x_q;

endmodule

// File: tb/tb_product_rr_scheduler.sv
// Directed bench for product_rr_scheduler with a behavioural down-counter product unit.
module tb_product_rr_scheduler;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  req_valid;
  logic [15:0] req_w, req_x;
  logic [3:0]  req_ready;
  logic        rsp_valid, rsp_ready;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_prod;
  logic        pu_load;
  logic [3:0]  pu_w, pu_x;
  logic        pu_out, pu_done;

  int n_vec = 0;
  int n_fail = 0;
  int cyc = 0;

  int pu_rem = 0;
  bit pu_active = 0;
  int pu_extra = 0;
  int pulses = 0;
  int n_loads = 0;
  int last_w = 0, last_x = 0;

  product_rr_scheduler #(.N_REQ(4), .WIDTH(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_w(req_w), .req_x(req_x), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_prod(rsp_prod),
    .pu_load(pu_load), .pu_w(pu_w), .pu_x(pu_x), .pu_out(pu_out), .pu_done(pu_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Product unit model: w*x (+pu_extra) pulses, pu_done with the last pulse.
  always @(negedge clk) begin
    pu_out  = 1'b0;
    pu_done = 1'b0;
    if (!reset_n) begin
      pu_active = 0;
    end else if (pu_active) begin
      if (pu_rem > 0) begin
        pu_out = 1'b1;
        pu_rem--;
        pulses++;
      end
      if (pu_rem == 0) begin
        pu_done   = 1'b1;
        pu_active = 0;
      end
    end else if (pu_load) begin
      pu_active = 1;
      pu_rem    = int'(pu_w) * int'(pu_x) + pu_extra;
      n_loads++;
      last_w = int'(pu_w);
      last_x = int'(pu_x);
    end
  end

  typedef struct {
    logic [3:0]  valid;
    logic [15:0] w;
    logic [15:0] x;
    int          exp_id;
    int          exp_prod;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wait_grant(output logic [3:0] g);
    g = '0;
    for (int c = 0; c < 100; c++) begin
      #1;
      if (req_ready != '0) begin
        g = req_ready;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_rsp(output logic ok);
    ok = 1'b0;
    for (int c = 0; c < 700; c++) begin
      #1;
      if (rsp_valid) begin
        ok = 1'b1;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic finish_rsp();
    @(negedge clk);
    #1;
    chk("rsp_valid_drop", {31'd0, rsp_valid}, 0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [3:0] g;
    logic       ok;
    int         loads0, c0, base;

    //           valid    w         x         id prod
    tbl[0] = '{4'b0001, 16'h0003, 16'h0005, 0, 15};
    tbl[1] = '{4'b0001, 16'h0002, 16'h0007, 0, 14};
    tbl[2] = '{4'b1001, 16'h4001, 16'h3001, 3, 12};
    tbl[3] = '{4'b0110, 16'h0650, 16'h0220, 1, 10};
    tbl[4] = '{4'b0110, 16'h0650, 16'h0220, 2, 12};
    tbl[5] = '{4'b0011, 16'h001F, 16'h001F, 0, 225};
    tbl[6] = '{4'b1111, 16'h2394, 16'h5891, 1, 81};

    reset_n = 1'b0; req_valid = '0; req_w = '0; req_x = '0; rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req_ready", {28'd0, req_ready}, 0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 0);
    chk("rst_rsp_id", {30'd0, rsp_id}, 0);
    chk("rst_rsp_prod", {24'd0, rsp_prod}, 0);
    chk("rst_pu_load", {31'd0, pu_load}, 0);
    chk("rst_pu_w", {28'd0, pu_w}, 0);
    chk("rst_pu_x", {28'd0, pu_x}, 0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      req_valid = tbl[i].valid; req_w = tbl[i].w; req_x = tbl[i].x;
      loads0 = n_loads;
      wait_grant(g);
      chk("tbl_grant", {28'd0, g}, 32'd1 << tbl[i].exp_id);
      @(negedge clk);
      req_valid = '0;
      wait_rsp(ok);
      chk("tbl_rsp_seen", {31'd0, ok}, 1);
      chk("tbl_rsp_id", {30'd0, rsp_id}, tbl[i].exp_id);
      chk("tbl_rsp_prod", {24'd0, rsp_prod}, tbl[i].exp_prod);
      chk("tbl_loads", n_loads - loads0, 1);
      chk("tbl_pu_w", last_w, {28'd0, tbl[i].w[tbl[i].exp_id*4 +: 4]});
      chk("tbl_pu_x", last_x, {28'd0, tbl[i].x[tbl[i].exp_id*4 +: 4]});
      finish_rsp();
    end

    // Zero operand on req2 (pointer is at 2)
    @(negedge clk);
    req_valid = 4'b0100; req_w = 16'h0000; req_x = 16'h0900;
    loads0 = n_loads;
    wait_grant(g);
    chk("zero_grant", {28'd0, g}, 4'b0100);
    c0 = cyc;
    @(negedge clk);
    req_valid = '0;
    wait_rsp(ok);
    chk("zero_rsp_seen", {31'd0, ok}, 1);
`ifdef ZERO_BYPASS_EN
    chk("zero_latency", cyc - c0, 1);
    chk("zero_loads", n_loads - loads0, 0);
`else
    chk("zero_latency", cyc - c0, 3);
    chk("zero_loads", n_loads - loads0, 1);
`endif
    chk("zero_rsp_id", {30'd0, rsp_id}, 2);
    chk("zero_rsp_prod", {24'd0, rsp_prod}, 0);
    finish_rsp();

    // Back-pressure: req1 3*3 held for 10 cycles while req0 waits
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 4'b0010; req_w = 16'h0030; req_x = 16'h0030;
    wait_grant(g);
    chk("bp_grant", {28'd0, g}, 4'b0010);
    @(negedge clk);
    req_valid = '0;
    wait_rsp(ok);
    chk("bp_rsp_seen", {31'd0, ok}, 1);
    loads0 = n_loads;
    req_valid = 4'b0001; req_w = 16'h0001; req_x = 16'h0002;
    for (int k = 0; k < 10; k++) begin
      chk("bp_rsp_valid", {31'd0, rsp_valid}, 1);
      chk("bp_rsp_id", {30'd0, rsp_id}, 1);
      chk("bp_rsp_prod", {24'd0, rsp_prod}, 9);
      chk("bp_req_ready", {28'd0, req_ready}, 0);
      @(negedge clk);
      #1;
    end
    chk("bp_no_load", n_loads - loads0, 0);
    rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("bp_rsp_drop", {31'd0, rsp_valid}, 0);
    chk("bp_next_grant", {28'd0, req_ready}, 4'b0001);
    @(negedge clk);
    req_valid = '0;
    wait_rsp(ok);
    chk("bp2_rsp_id", {30'd0, rsp_id}, 0);
    chk("bp2_rsp_prod", {24'd0, rsp_prod}, 2);
    finish_rsp();

    // Saturation: unit over-counts to 265 pulses
    @(negedge clk);
    pu_extra = 40;
    req_valid = 4'b1000; req_w = 16'hF000; req_x = 16'hF000;
    wait_grant(g);
    chk("sat_grant", {28'd0, g}, 4'b1000);
    @(negedge clk);
    req_valid = '0;
    wait_rsp(ok);
    chk("sat_rsp_id", {30'd0, rsp_id}, 3);
    chk("sat_rsp_prod", {24'd0, rsp_prod}, 255);
    finish_rsp();
    pu_extra = 0;

    // Reset after 7 pulses of a req1 4*4 job
    @(negedge clk);
    req_valid = 4'b0010; req_w = 16'h0040; req_x = 16'h0040;
    wait_grant(g);
    chk("mid_grant", {28'd0, g}, 4'b0010);
    @(negedge clk);
    req_valid = '0;
    base = pulses;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      #1;
      if (pulses - base >= 7) break;
    end
    chk("mid_pulses", pulses - base, 7);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_rsp_valid", {31'd0, rsp_valid}, 0);
    chk("mid_rst_pu_load", {31'd0, pu_load}, 0);
    chk("mid_rst_req_ready", {28'd0, req_ready}, 0);
    chk("mid_rst_rsp_id", {30'd0, rsp_id}, 0);
    chk("mid_rst_rsp_prod", {24'd0, rsp_prod}, 0);
    chk("mid_rst_pu_w", {28'd0, pu_w}, 0);
    chk("mid_rst_pu_x", {28'd0, pu_x}, 0);
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("mid_rst_hold_valid", {31'd0, rsp_valid}, 0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    req_valid = 4'b1010; req_w = 16'h7020; req_x = 16'h1020;
    wait_grant(g);
    chk("mid_after_grant", {28'd0, g}, 4'b0010);
    @(negedge clk);
    req_valid = '0;
    wait_rsp(ok);
    chk("mid_after_rsp_id", {30'd0, rsp_id}, 1);
    chk("mid_after_rsp_prod", {24'd0, rsp_prod}, 4);
    finish_rsp();

    // Round robin with all requesters held valid from reset
    pulse_reset();
    req_valid = 4'b1111; req_w = 16'h2222; req_x = 16'h4321;
    for (int k = 0; k < 5; k++) begin
      wait_grant(g);
      chk("rr_grant", {28'd0, g}, 32'd1 << (k % 4));
      wait_rsp(ok);
      chk("rr_rsp_id", {30'd0, rsp_id}, k % 4);
      chk("rr_rsp_prod", {24'd0, rsp_prod}, 2 * ((k % 4) + 1));
      finish_rsp();
    end
    req_valid = '0;

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
